pulse_burst_gen: RTL and testbench

//  Event transmitter: emits a programmed burst of single-cycle pulses on 'pulse'.

---
 rtl/pulse_burst_gen.sv | 110 +++++++++++
 tb/tb_pulse_burst_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_gen.sv
// Burst transmitter: emits burst_len single-cycle pulses separated by GAP idle cycles, then strobes done.
// Optional feature macro: PULSE_BURST_ABORT_EN adds an 'abort' input that cancels a running burst without done.
module pulse_burst_gen #(
   parameter int CNT_W = 4,
   parameter int GAP   = 1,
   parameter int GAP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
`ifdef PULSE_BURST_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             pulse,
   output logic [CNT_W-1:0] remaining,
   output logic             done
);

   // state   | meaning
   // S_IDLE  | waiting for start; done cycle is also spent here
   // S_PULSE | pulse high this cycle
   // S_GAP   | low cycles between pulses, gap_q counts down to 0
   typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

   localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

   state_t             state_q, state_nx;
   logic [CNT_W-1:0]   rem_nx;
   logic [GAP_W-1:0]   gap_q, gap_nx;
   logic               done_nx, pulse_nx, busy_nx;
   logic               abort_hit;

`ifdef PULSE_BURST_ABORT_EN
   assign abort_hit = abort && (state_q != S_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         remaining <= '0;
         gap_q     <= '0;
         done      <= 1'b0;
         pulse     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_nx;
         remaining <= rem_nx;
         gap_q     <= gap_nx;
         done      <= done_nx;
         pulse     <= pulse_nx;
         busy      <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      rem_nx   = remaining;
      gap_nx   = gap_q;
      done_nx  = 1'b0;
      if (abort_hit) begin
         state_nx = S_IDLE;
         rem_nx   = '0;
         gap_nx   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (burst_len == '0) begin
                     done_nx = 1'b1;
                  end else begin
                     state_nx = S_PULSE;
                     rem_nx   = burst_len - CNT_W'(1);
                  end
               end
            end
            S_PULSE: begin
               if (remaining == '0) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end else if (GAP == 0) begin
                  rem_nx = remaining - CNT_W'(1);
               end else begin
                  state_nx = S_GAP;
                  gap_nx   = GAP_LOAD;
               end
            end
            S_GAP: begin
               if (gap_q == '0) begin
                  state_nx = S_PULSE;
                  if (remaining != '0) rem_nx = remaining - CNT_W'(1);
               end else begin
                  gap_nx = gap_q - GAP_W'(1);
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they land in flops alongside it.
   always_comb begin
      pulse_nx = (state_nx == S_PULSE);
      busy_nx  = (state_nx != S_IDLE);
   end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Self-checking bench for pulse_burst_gen: three instances (GAP=1,0,2) share stimulus,
// each compared against a schedule-queue model; directed tables cover the corner cases.
module tb_pulse_burst_gen;

`ifdef PULSE_BURST_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   typedef struct packed {
      logic       p;
      logic       b;
      logic [3:0] r;
      logic       d;
   } exp_t;

   typedef struct {
      logic       s;
      logic [3:0] len;
      logic       p;
      logic       b;
      logic [3:0] r;
      logic       d;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] burst_len;
   logic       abort_i;
   logic [2:0] pulse_w, busy_w, done_w;
   logic [3:0] rem_w [3];

   int checks = 0;
   int errors = 0;
   int gaps [3] = '{1, 0, 2};
   exp_t mq [3][$];
   vec_t tbl [$];

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_dut
      localparam int GV = (i == 0) ? 1 : ((i == 1) ? 0 : 2);
      pulse_burst_gen #(.CNT_W(4), .GAP(GV), .GAP_W(8)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .start     (start),
         .burst_len (burst_len),
`ifdef PULSE_BURST_ABORT_EN
         .abort     (abort_i),
`endif
         .busy      (busy_w[i]),
         .pulse     (pulse_w[i]),
         .remaining (rem_w[i]),
         .done      (done_w[i])
      );
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t cur(input int d);
      if (mq[d].size() > 0) return mq[d][0];
      return '0;
   endfunction

   // Whole burst is expanded into its per-cycle outputs the moment it is accepted.
   task automatic model_edge(input logic s, input logic [3:0] len, input logic ab);
      for (int d = 0; d < 3; d++) begin
         bit busy_now;
         int n;
         busy_now = (mq[d].size() > 0) && mq[d][0].b;
         if (ABORT_EN && ab && busy_now) begin
            mq[d].delete();
            continue;
         end
         if (mq[d].size() > 0) void'(mq[d].pop_front());
         if (!busy_now && s) begin
            n = int'(len);
            for (int k = 0; k < n; k++) begin
               mq[d].push_back('{p: 1'b1, b: 1'b1, r: 4'(n - 1 - k), d: 1'b0});
               if (k < n - 1)
                  for (int g = 0; g < gaps[d]; g++)
                     mq[d].push_back('{p: 1'b0, b: 1'b1, r: 4'(n - 1 - k), d: 1'b0});
            end
            mq[d].push_back('{p: 1'b0, b: 1'b0, r: 4'd0, d: 1'b1});
         end
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 3; d++) begin
         exp_t e;
         e = cur(d);
         chk($sformatf("m%0d pulse", d), int'(pulse_w[d]), int'(e.p));
         chk($sformatf("m%0d busy", d), int'(busy_w[d]), int'(e.b));
         chk($sformatf("m%0d remaining", d), int'(rem_w[d]), int'(e.r));
         chk($sformatf("m%0d done", d), int'(done_w[d]), int'(e.d));
      end
   endtask

   task automatic step(input logic s, input logic [3:0] len, input logic ab);
      start = s;
      burst_len = len;
      abort_i = ab;
      @(posedge clk);
      model_edge(s, len, ab);
      #1;
      check_model();
   endtask

   task automatic check_all_zero(input string nm);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s pulse%0d", nm, d), int'(pulse_w[d]), 0);
         chk($sformatf("%s busy%0d", nm, d), int'(busy_w[d]), 0);
         chk($sformatf("%s remaining%0d", nm, d), int'(rem_w[d]), 0);
         chk($sformatf("%s done%0d", nm, d), int'(done_w[d]), 0);
      end
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0;
      start = 1'b0;
      burst_len = 4'd0;
      abort_i = 1'b0;

      // GAP=1 instance (index 0): N=3, N=0, start held through an N=4 burst
      tbl.push_back('{1'b1, 4'd3, 1'b1, 1'b1, 4'd2, 1'b0});
      tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0});
      tbl.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0});
      tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0});
      tbl.push_back('{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0});
      tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1});
      tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0});
      tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1});
      tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0});
      tbl.push_back('{1'b1, 4'd4, 1'b1, 1'b1, 4'd3, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b0, 1'b1, 4'd3, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b1, 1'b1, 4'd2, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b0, 1'b1, 4'd2, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b1, 1'b1, 4'd1, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b0, 1'b1, 4'd1, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0});
      tbl.push_back('{1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b1});
      tbl.push_back('{1'b1, 4'd7, 1'b1, 1'b1, 4'd6, 1'b0});

      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      cnt = 0;
      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].len, 1'b0);
         if (i < 7) cnt += int'(pulse_w[0]);
         chk($sformatf("tbl%0d pulse", i), int'(pulse_w[0]), int'(tbl[i].p));
         chk($sformatf("tbl%0d busy", i), int'(busy_w[0]), int'(tbl[i].b));
         chk($sformatf("tbl%0d remaining", i), int'(rem_w[0]), int'(tbl[i].r));
         chk($sformatf("tbl%0d done", i), int'(done_w[0]), int'(tbl[i].d));
         if (i == 6) chk("n3 gap1 pulse count", cnt, 3);
      end
      for (int k = 0; k < 30; k++) step(1'b0, 4'd0, 1'b0);

      // GAP=0 instance (index 1): max burst, back-to-back, no wrap
      step(1'b1, 4'd15, 1'b0);
      chk("max first remaining", int'(rem_w[1]), 14);
      cnt = int'(pulse_w[1]);
      for (int k = 1; k < 15; k++) begin
         step(1'b0, 4'd0, 1'b0);
         cnt += int'(pulse_w[1]);
      end
      chk("max pulse count", cnt, 15);
      chk("max last remaining", int'(rem_w[1]), 0);
      step(1'b0, 4'd0, 1'b0);
      chk("max done 16th", int'(done_w[1]), 1);
      chk("max pulse 16th", int'(pulse_w[1]), 0);
      chk("max remaining 16th", int'(rem_w[1]), 0);
      for (int k = 0; k < 50; k++) step(1'b0, 4'd0, 1'b0);

      // asynchronous reset in the middle of an N=5 burst
      step(1'b1, 4'd5, 1'b0);
      step(1'b0, 4'd0, 1'b0);
      chk("pre-reset pulse", int'(pulse_w[1]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midburst reset");
      for (int d = 0; d < 3; d++) mq[d].delete();
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 4'd0, 1'b0);
         cnt += int'(pulse_w[1]);
      end
      chk("post-reset pulses", cnt, 0);

`ifdef PULSE_BURST_ABORT_EN
      // GAP=2 instance (index 2): abort right after the 2nd pulse
      cnt = 0;
      step(1'b1, 4'd6, 1'b0);
      cnt += int'(pulse_w[2]);
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 4'd0, 1'b0);
         cnt += int'(pulse_w[2]);
      end
      chk("abort pre pulse", int'(pulse_w[2]), 1);
      step(1'b1, 4'd9, 1'b1);
      chk("abort pulse", int'(pulse_w[2]), 0);
      chk("abort busy", int'(busy_w[2]), 0);
      chk("abort remaining", int'(rem_w[2]), 0);
      chk("abort done", int'(done_w[2]), 0);
      step(1'b0, 4'd0, 1'b0);
      chk("abort done after", int'(done_w[2]), 0);
      cnt += int'(pulse_w[2]);
      chk("abort pulse count", cnt, 2);
`endif

      for (int k = 0; k < 600; k++) begin
         logic s, ab;
         logic [3:0] len;
         s = ($urandom_range(0, 3) == 0);
         len = 4'($urandom_range(0, 15));
         ab = ABORT_EN && ($urandom_range(0, 24) == 0);
         step(s, len, ab);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
